// File: rtl/paillier_enc_feeder.sv
// Paillier encoder operand feeder: buffers n/m/r/g words and streams them LSW-first after a request/gap handshake.
// Define PAILLIER_G_AUTO_EN to drop the g buffer and stream g = n + 1 computed word-serially.
module paillier_enc_feeder #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [CW-1:0] wr_addr,
  input  logic [K-1:0]  wr_data,
  output logic          wr_err,
  input  logic          start,
  input  logic [2:0]    cmd_in,
  output logic          busy,
  output logic          done,
  output logic [2:0]    task_cmd,
  output logic          task_req,
  output logic [K-1:0]  enc_g_data,
  output logic          enc_g_valid,
  output logic [K-1:0]  enc_m_data,
  output logic          enc_m_valid,
  output logic [K-1:0]  enc_r_data,
  output logic          enc_r_valid,
  output logic [K-1:0]  enc_n_data,
  output logic          enc_n_valid,
  input  logic          enc_out_valid
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_idx, r_beats, w_rd;
  logic          w_load, w_wr_ok, w_wr_rej, w_last_beat;
  logic          r_busy, r_done, r_task_req, r_wr_err, r_vld;
  logic [2:0]    r_task_cmd;
  logic [K-1:0]  r_n, r_m, r_r, r_g, w_g_word;
  logic [K-1:0]  r_nbuf [N];
  logic [K-1:0]  r_mbuf [N];
  logic [K-1:0]  r_rbuf [N];
`ifdef PAILLIER_G_AUTO_EN
  logic          r_gc, w_gcin, w_gc_nxt;
`else
  logic [K-1:0]  r_gbuf [N];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_beat = enc_out_valid && (r_beats == CW'(N-1));
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_GAP;
      S_GAP:  w_state_nxt = S_SEND;
      S_SEND: if (r_idx == CW'(N-1)) w_state_nxt = S_WAIT;
      S_WAIT: if (w_last_beat) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word to present next cycle: 0 on entry from GAP, otherwise the successor of the current word.
  always_comb begin
    w_load  = (w_state_nxt == S_SEND);
    w_rd    = (r_state == S_SEND) ? r_idx + 1'b1 : '0;
    w_wr_ok = wr_en && (r_state == S_IDLE);
`ifdef PAILLIER_G_AUTO_EN
    w_wr_rej = wr_en && (r_state != S_IDLE) && (wr_sel != 2'd3);
    w_gcin   = (r_state == S_GAP) ? 1'b1 : r_gc;
    w_g_word = r_nbuf[w_rd] + K'(w_gcin);
    w_gc_nxt = w_gcin & (&r_nbuf[w_rd]);
`else
    w_wr_rej = wr_en && (r_state != S_IDLE);
    w_g_word = r_gbuf[w_rd];
`endif
  end

  // Operand storage is deliberately left out of reset so a host load survives an abort.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      case (wr_sel)
        2'd0: r_nbuf[wr_addr] <= wr_data;
        2'd1: r_mbuf[wr_addr] <= wr_data;
        2'd2: r_rbuf[wr_addr] <= wr_data;
`ifndef PAILLIER_G_AUTO_EN
        2'd3: r_gbuf[wr_addr] <= wr_data;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_task_req <= 1'b0;
      r_task_cmd <= '0;
      r_wr_err   <= 1'b0;
      r_vld      <= 1'b0;
      r_idx      <= '0;
      r_beats    <= '0;
      r_n        <= '0;
      r_m        <= '0;
      r_r        <= '0;
      r_g        <= '0;
`ifdef PAILLIER_G_AUTO_EN
      r_gc       <= 1'b0;
`endif
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_task_req <= (w_state_nxt == S_REQ);
      if (r_state == S_IDLE && start) r_task_cmd <= cmd_in;
      r_wr_err   <= w_wr_rej;
      r_vld      <= w_load;
      r_idx      <= w_load ? w_rd : '0;
      r_n        <= w_load ? r_nbuf[w_rd] : '0;
      r_m        <= w_load ? r_mbuf[w_rd] : '0;
      r_r        <= w_load ? r_rbuf[w_rd] : '0;
      r_g        <= w_load ? w_g_word : '0;
`ifdef PAILLIER_G_AUTO_EN
      if (w_load) r_gc <= w_gc_nxt;
`endif
      if (r_state != S_WAIT || w_last_beat) r_beats <= '0;
      else if (enc_out_valid)               r_beats <= r_beats + 1'b1;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign task_req    = r_task_req;
  assign task_cmd    = r_task_cmd;
  assign wr_err      = r_wr_err;
  assign enc_n_valid = r_vld;
  assign enc_m_valid = r_vld;
  assign enc_r_valid = r_vld;
  assign enc_g_valid = r_vld;
  assign enc_n_data  = r_n;
  assign enc_m_data  = r_m;
  assign enc_r_data  = r_r;
  assign enc_g_data  = r_g;

endmodule

// File: tb/tb_paillier_enc_feeder.sv
// Directed bench for paillier_enc_feeder: load, stream, write/start rejection, beat counting, mid-stream reset.
module tb_paillier_enc_feeder;
  localparam int K = 128, N = 32, CW = $clog2(N);

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, start = 1'b0, enc_out_valid = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [CW-1:0] wr_addr = '0;
  logic [K-1:0] wr_data = '0;
  logic [2:0] cmd_in = '0;
  logic wr_err, busy, done, task_req;
  logic [2:0] task_cmd;
  logic [K-1:0] enc_g_data, enc_m_data, enc_r_data, enc_n_data;
  logic enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid;

  logic [K-1:0] n_m [N];
  logic [K-1:0] m_m [N];
  logic [K-1:0] r_m [N];
  logic [K-1:0] g_m [N];
  logic [K-1:0] g_exp [N];
  int n_chk = 0, n_err = 0;

  paillier_enc_feeder #(.K(K), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .cmd_in(cmd_in),
    .busy(busy), .done(done), .task_cmd(task_cmd), .task_req(task_req),
    .enc_g_data(enc_g_data), .enc_g_valid(enc_g_valid),
    .enc_m_data(enc_m_data), .enc_m_valid(enc_m_valid),
    .enc_r_data(enc_r_data), .enc_r_valid(enc_r_valid),
    .enc_n_data(enc_n_data), .enc_n_valid(enc_n_valid),
    .enc_out_valid(enc_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int a, input logic [K-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = CW'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // g = n + 1 word-serially when the auto option is built in, else the g buffer.
  task automatic prep_g();
    logic c;
    c = 1'b1;
    for (int i = 0; i < N; i++) begin
`ifdef PAILLIER_G_AUTO_EN
      g_exp[i] = n_m[i] + K'(c);
      c = c & (n_m[i] == {K{1'b1}});
`else
      g_exp[i] = g_m[i];
`endif
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".busy"}, K'(busy), '0);
    chk({tag, ".done"}, K'(done), '0);
    chk({tag, ".wr_err"}, K'(wr_err), '0);
    chk({tag, ".task_req"}, K'(task_req), '0);
    chk({tag, ".task_cmd"}, K'(task_cmd), '0);
    chk({tag, ".valids"}, K'({enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid}), '0);
    chk({tag, ".n"}, enc_n_data, '0);
    chk({tag, ".m"}, enc_m_data, '0);
    chk({tag, ".r"}, enc_r_data, '0);
    chk({tag, ".g"}, enc_g_data, '0);
  endtask

  // Request, gap and N stream beats; enc_out_valid is held high throughout as noise that must be ignored.
  task automatic run_stream(input logic [2:0] cmd, input int wr_at, input int rst_at);
    prep_g();
    start = 1'b1; cmd_in = cmd;
    cyc();
    start = 1'b0; cmd_in = ~cmd;
    @(negedge clk);
    chk("req.task_req", K'(task_req), K'(1));
    chk("req.task_cmd", K'(task_cmd), K'(cmd));
    chk("req.busy", K'(busy), K'(1));
    chk("req.valid", K'(enc_n_valid), '0);
    cyc();
    enc_out_valid = 1'b1;
    @(negedge clk);
    chk("gap.task_req", K'(task_req), '0);
    chk("gap.valids", K'({enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid}), '0);
    chk("gap.n", enc_n_data, '0);
    chk("gap.g", enc_g_data, '0);
    for (int i = 0; i < N; i++) begin
      cyc();
      wr_en = 1'b0;
      @(negedge clk);
      chk($sformatf("send%0d.valids", i), K'({enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid}), K'(4'hF));
      chk($sformatf("send%0d.n", i), enc_n_data, n_m[i]);
      chk($sformatf("send%0d.m", i), enc_m_data, m_m[i]);
      chk($sformatf("send%0d.r", i), enc_r_data, r_m[i]);
      chk($sformatf("send%0d.g", i), enc_g_data, g_exp[i]);
      chk($sformatf("send%0d.wr_err", i), K'(wr_err), K'(i == wr_at + 1 && wr_at >= 0));
      if (i == wr_at) begin
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = CW'(5); wr_data = 128'hBAD0_BAD0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        enc_out_valid = 1'b0;
        @(negedge clk);
        chk_idle_outs("rst_mid");
        return;
      end
    end
  endtask

  task automatic wait_phase(input logic [2:0] cmd, input bit start_in_wait);
    for (int b = 1; b <= N; b++) begin
      cyc();
      start = 1'b0;
      enc_out_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("beat%0d.done", b), K'(done), '0);
      chk($sformatf("beat%0d.busy", b), K'(busy), K'(1));
      if (b == 11 && start_in_wait) begin
        chk("wait_start.task_req", K'(task_req), '0);
        chk("wait_start.task_cmd", K'(task_cmd), K'(cmd));
      end
      if (b % 10 == 0 && b < N) begin
        cyc();
        enc_out_valid = 1'b0;
        if (b == 10 && start_in_wait) begin
          start = 1'b1; cmd_in = 3'b111;
        end
        @(negedge clk);
        chk($sformatf("idle%0d.done", b), K'(done), '0);
      end
    end
    cyc();
    enc_out_valid = 1'b0;
    @(negedge clk);
    chk("done.done", K'(done), K'(1));
    chk("done.busy", K'(busy), K'(1));
    cyc();
    @(negedge clk);
    chk("post.done", K'(done), '0);
    chk("post.busy", K'(busy), '0);
    chk("post.task_cmd", K'(task_cmd), K'(cmd));
    chk("post.n_data", enc_n_data, '0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      n_m[i] = (i < 16) ? '0 : {32'hDEADBEEF ^ 32'(i), 64'h0123_4567_89AB_CDEF, 32'(i)};
      m_m[i] = (i == 0) ? 128'h1000000019091 : '0;
      r_m[i] = (i == 0) ? 128'h100000000000007b : '0;
      g_m[i] = {32'(i) + 32'h7000_0000, 96'hC0FFEE};
    end

    cyc(); cyc();
    @(negedge clk);
    chk_idle_outs("reset");
    rst = 1'b0;
    cyc();

    for (int i = 0; i < N; i++) begin
      wr(2'd0, i, n_m[i]);
      wr(2'd1, i, m_m[i]);
      wr(2'd2, i, r_m[i]);
      wr(2'd3, i, g_m[i]);
    end
    @(negedge clk);
    chk("load.wr_err", K'(wr_err), '0);
    chk("load.busy", K'(busy), '0);

    // Run 1: write rejected during SEND, start ignored during WAIT.
    run_stream(3'b000, 5, -1);
    wait_phase(3'b000, 1'b1);

    // Run 2: buffers must still hold the original m[5].
    run_stream(3'b101, -1, -1);
    wait_phase(3'b101, 1'b0);

    // Carry-chain load, then an aborted run and a clean replay.
    n_m[0] = {K{1'b1}};
    n_m[1] = 128'd5;
    cyc();
    wr(2'd0, 0, n_m[0]);
    wr(2'd0, 1, n_m[1]);
    run_stream(3'b010, -1, 10);
    cyc();
    run_stream(3'b010, -1, -1);
    wait_phase(3'b010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/paillier_enc_feeder.md
PAILLIER_ENC_FEEDER -- requirements
Module: paillier_enc_feeder

Interface
REQ-001 Parameters SHALL be: K, 128, operand word width in bits; N, 32, words per operand; CW, $clog2(N), word-address width.
REQ-002 Ports SHALL be, in order:
- clk, input, 1, sole clock
- rst, input, 1, synchronous active-high reset
- wr_en, input, 1, host operand word write strobe
- wr_sel, input, 2, target operand: 0=n, 1=m, 2=r, 3=g
- wr_addr, input, CW, word index; 0 = least significant
- wr_data, input, K, word value
- wr_err, output, 1, write rejected
- start, input, 1, launch request
- cmd_in, input, 3, command for the encoder
- busy, output, 1, operation in progress
- done, output, 1, operation complete
- task_cmd, output, 3, encoder command
- task_req, output, 1, encoder request
- enc_g_data, output, K, g stream data
- enc_g_valid, output, 1, g stream valid
- enc_m_data, output, K, m stream data
- enc_m_valid, output, 1, m stream valid
- enc_r_data, output, K, r stream data
- enc_r_valid, output, 1, r stream valid
- enc_n_data, output, K, n stream data
- enc_n_valid, output, 1, n stream valid
- enc_out_valid, input, 1, encoder result beat, monitored only
REQ-003 All outputs SHALL be registered.

Function
REQ-004 Four N x K operand buffers (n, m, r, g) SHALL be written when wr_en=1 in IDLE: buf[wr_sel][wr_addr] <= wr_data.
REQ-005 wr_en=1 outside IDLE SHALL leave all buffers unchanged and pulse wr_err for one cycle, one cycle after the rejected write.
REQ-006 The state machine SHALL have states IDLE, REQ, GAP, SEND, WAIT, DONE.
REQ-007 IDLE: start=1 SHALL latch cmd_in and enter REQ. start=1 in any other state SHALL be ignored.
REQ-008 REQ (1 cycle): task_req=1 and task_cmd=latched cmd; the next state SHALL be GAP.
REQ-009 GAP (1 cycle): task_req=0 and all valids 0; the next state SHALL be SEND.
REQ-010 SEND (exactly N cycles): in cycle i, all four valids SHALL be 1 and each data port SHALL carry buffer word i, i=0..N-1, LSW first, with no gaps; after word N-1 the next state SHALL be WAIT.
REQ-011 WAIT: a counter SHALL count cycles with enc_out_valid=1; on the N-th beat the next state SHALL be DONE. Beats outside WAIT SHALL be ignored.
REQ-012 DONE (1 cycle): done=1; the next state SHALL be IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Timing: start sampled at edge 0 SHALL give task_req high in cycle 1, first valid data in cycle 3, last in cycle N+2.
REQ-015 Data ports SHALL be 0 whenever their valid is 0.
REQ-016 task_cmd SHALL hold the latched command from REQ until the next start.

Reset
REQ-017 rst=1 at any clock edge, including mid-SEND or mid-WAIT, SHALL force IDLE and clear the counters.
REQ-018 Under rst=1, busy, done, wr_err, task_req, all valids, all data ports and task_cmd SHALL be 0.
REQ-019 Buffer contents SHALL NOT be cleared by reset.
REQ-020 After rst deasserts, a new start SHALL behave per REQ-014.

Configuration
REQ-021 With PAILLIER_G_AUTO_EN defined, the g buffer SHALL be omitted and enc_g_data SHALL be n+1 computed word-serially.
- enc_g_data word i = n[i] + c(i) mod 2^K, with c(0)=1 and c(i+1)=c(i) AND (n[i] all ones).
- Carry out of word N-1 is discarded.
- Writes with wr_sel=3 are ignored with no wr_err.
REQ-022 Without PAILLIER_G_AUTO_EN, the g stream SHALL come from the g buffer per REQ-010.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load n words 0..15 = 0, words 16..31 = distinct 128-bit values; m[0]=0x1000000019091, r[0]=0x100000000000007b, other m/r words 0; start with cmd_in=3'b000 -> task_req one cycle, gap one cycle, 32 consecutive valid beats, word 0 first and matching buffers.
- Same load with PAILLIER_G_AUTO_EN defined and n[0]=0xFFFF...FF, n[1]=5 -> g word 0 = 0, g word 1 = 6, all other g words = n.
- Write during SEND -> wr_err pulse, readback on the next run shows the old data; start during WAIT -> ignored.
- After SEND, drive 32 enc_out_valid beats with 3 idle cycles inserted -> done exactly one cycle after beat 32, busy low the next cycle.
- Assert rst in SEND cycle 10 -> all outputs 0 the next cycle; a following start replays the full run with buffers intact.
